serializer: RTL and testbench

//  Transmit side of the FSK link's 12-bit UART-style frame. Accepts a parallel word
//  on a one-cycle start strobe and shifts it onto the serial line as a framed bit stream.

---
 rtl/serializer.sv | 159 +++++++++++++++
 tb/tb_serializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// ---------------------------------------------------------------------------
// serializer
//   Transmit side of the FSK link. Takes a parallel word on a one-cycle start
//   strobe and sends it on a serial line as a UART-style frame: one start
//   bit (0), then DATA_W data bits LSB first, then STOP_BITS stop bits (1).
//   Each bit is held for BIT_CLKS clocks. A new word can be accepted in the
//   last cycle of the final stop bit, so frames can run with no gap.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst_n     in   asynchronous active-low reset
//   TX_Data   in   word to send, sampled only when a start is accepted
//   TX_Start  in   request strobe, accepted only while TX_Ready=1
//   TX_Ready  out  combinational: a start is accepted this cycle
//   TX_Busy   out  registered: a frame is in progress
//   TX_Done   out  registered one-cycle pulse at frame completion
//   UART_TX   out  registered serial line, idles high
// ---------------------------------------------------------------------------
module serializer #(
  parameter int DATA_W    = 12,
  parameter int BIT_CLKS  = 16,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] TX_Data,
  input  logic              TX_Start,
  output logic              TX_Ready,
  output logic              TX_Busy,
  output logic              TX_Done,
  output logic              UART_TX
);

  localparam int CNT_W = $clog2(BIT_CLKS);
  // idx holds either a data-bit or a stop-bit number; size for the larger.
  localparam int IDX_W = $clog2(DATA_W + STOP_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic end_of_bit;
  logic last_stop;
  logic accept;

  assign end_of_bit = (bit_cnt_q == CNT_LAST);
  assign last_stop  = (state_q == STOP) && (idx_q == STOP_LAST) && end_of_bit;
  assign TX_Ready   = (state_q == IDLE) || last_stop;
  assign accept     = TX_Start && TX_Ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    // Bit timer free-runs while a frame is active and wraps at each bit end.
    if (state_q == IDLE || end_of_bit) begin
      bit_cnt_d = '0;
    end else begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shreg_d = TX_Data;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (end_of_bit) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (end_of_bit) begin
          if (idx_q == DATA_LAST) begin
            state_d = STOP;
            idx_d   = '0;
            tx_d    = 1'b1;
          end else begin
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_d[0];
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (end_of_bit) begin
          if (idx_q == STOP_LAST) begin
            done_d = 1'b1;
            if (accept) begin
              // Gapless hand-off: next start bit follows the stop bit directly.
              state_d = START;
              shreg_d = TX_Data;
              idx_d   = '0;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign TX_Busy = busy_q;
  assign TX_Done = done_q;
  assign UART_TX = tx_q;

endmodule

// File: tb/tb_serializer.sv
// ---------------------------------------------------------------------------
// tb_serializer
//   Directed bench for the serializer at default parameters (12 data bits,
//   16 clocks per bit, 1 stop bit, 224-clock frame). Outputs are sampled on
//   the falling clock edge; inputs are driven on the falling edge as well.
// ---------------------------------------------------------------------------
module tb_serializer;

  localparam int DATA_W   = 12;
  localparam int BIT_CLKS = 16;
  localparam int FRAME    = (1 + DATA_W + 1) * BIT_CLKS;  // 224
  localparam int N_LOOP   = 200;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] TX_Data = '0;
  logic              TX_Start = 1'b0;
  logic              TX_Ready;
  logic              TX_Busy;
  logic              TX_Done;
  logic              UART_TX;

  int errors = 0;
  int checks = 0;

  serializer #(
    .DATA_W   (DATA_W),
    .BIT_CLKS (BIT_CLKS),
    .STOP_BITS(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .TX_Data (TX_Data),
    .TX_Start(TX_Start),
    .TX_Ready(TX_Ready),
    .TX_Busy (TX_Busy),
    .TX_Done (TX_Done),
    .UART_TX (UART_TX)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line level in frame cycle c for word d (start, data LSB first, stop).
  function automatic logic frame_bit(input logic [DATA_W-1:0] d, input int c);
    int k;
    k = c / BIT_CLKS;
    if (k == 0) return 1'b0;
    if (k <= DATA_W) return d[k-1];
    return 1'b1;
  endfunction

  // Called at the falling edge just after the accepting rising edge (c=0).
  // Checks every cycle of the frame and returns at c=FRAME (Done cycle),
  // or at c=abort if abort >= 0. A foreign start strobe with 12'h123 is
  // injected for one cycle at c=inject if inject >= 0.
  task automatic check_frame(input string tag, input logic [DATA_W-1:0] d,
                             input int inject, input int abort);
    for (int c = 0; c < FRAME; c++) begin
      if (c == abort) return;
      chk({tag, "_line"}, {31'd0, UART_TX}, {31'd0, frame_bit(d, c)});
      chk({tag, "_busy"}, {31'd0, TX_Busy}, 32'd1);
      if (c > 0) chk({tag, "_done_low"}, {31'd0, TX_Done}, 32'd0);
      chk({tag, "_ready"}, {31'd0, TX_Ready}, (c == FRAME - 1) ? 32'd1 : 32'd0);
      if (c == inject) begin
        TX_Start = 1'b1;
        TX_Data  = 12'h123;
      end else if (inject >= 0 && c == inject + 1) begin
        TX_Start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] words [N_LOOP];
    logic [DATA_W-1:0] rx;
    logic              bad_framing;

    // ---- 1: asynchronous reset ----
    #2 rst_n = 1'b0;
    #1;
    chk("rst_line",  {31'd0, UART_TX},  32'd1);
    chk("rst_busy",  {31'd0, TX_Busy},  32'd0);
    chk("rst_done",  {31'd0, TX_Done},  32'd0);
    chk("rst_ready", {31'd0, TX_Ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_line",  {31'd0, UART_TX},  32'd1);
    chk("idle_ready", {31'd0, TX_Ready}, 32'd1);
    $display("reset: done");

    // ---- 2: single frame 12'hA5C ----
    TX_Data = 12'hA5C; TX_Start = 1'b1;
    @(negedge clk);
    TX_Start = 1'b0;
    check_frame("single", 12'hA5C, -1, -1);
    chk("single_done", {31'd0, TX_Done}, 32'd1);
    chk("single_busy_end", {31'd0, TX_Busy}, 32'd0);
    chk("single_line_end", {31'd0, UART_TX}, 32'd1);
    @(negedge clk);
    chk("single_done_pulse", {31'd0, TX_Done}, 32'd0);
    $display("frame single data=a5c");
    repeat (4) @(negedge clk);

    // ---- 3: back-to-back 12'h001 then 12'hFFF, start held ----
    TX_Data = 12'h001; TX_Start = 1'b1;
    @(negedge clk);
    TX_Data = 12'hFFF;
    check_frame("b2b_a", 12'h001, -1, -1);
    chk("b2b_done_a", {31'd0, TX_Done}, 32'd1);
    chk("b2b_busy_gap", {31'd0, TX_Busy}, 32'd1);
    chk("b2b_no_idle", {31'd0, UART_TX}, 32'd0);
    TX_Start = 1'b0;
    check_frame("b2b_b", 12'hFFF, -1, -1);
    chk("b2b_done_b", {31'd0, TX_Done}, 32'd1);
    chk("b2b_busy_end", {31'd0, TX_Busy}, 32'd0);
    @(negedge clk);
    chk("b2b_done_pulse", {31'd0, TX_Done}, 32'd0);
    $display("frame b2b data=001,fff");
    repeat (4) @(negedge clk);

    // ---- 4: start pulsed mid-frame is ignored ----
    TX_Data = 12'h6B1; TX_Start = 1'b1;
    @(negedge clk);
    TX_Start = 1'b0;
    check_frame("midstart", 12'h6B1, 50, -1);
    chk("midstart_done", {31'd0, TX_Done}, 32'd1);
    chk("midstart_busy_end", {31'd0, TX_Busy}, 32'd0);
    repeat (20) begin
      @(negedge clk);
      chk("midstart_no_frame", {31'd0, TX_Busy}, 32'd0);
      chk("midstart_one_done", {31'd0, TX_Done}, 32'd0);
    end
    TX_Data = 12'h000;
    $display("frame midstart data=6b1");

    // ---- 5: reset at clk 100 of a frame ----
    TX_Data = 12'h3C6; TX_Start = 1'b1;
    @(negedge clk);
    TX_Start = 1'b0;
    check_frame("abort", 12'h3C6, -1, 100);
    chk("abort_line_pre", {31'd0, UART_TX}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_line_async", {31'd0, UART_TX},  32'd1);
    chk("abort_busy_async", {31'd0, TX_Busy},  32'd0);
    chk("abort_ready",      {31'd0, TX_Ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, TX_Done}, 32'd0);
      chk("abort_line_idle", {31'd0, UART_TX}, 32'd1);
    end
    TX_Data = 12'h3C6; TX_Start = 1'b1;
    @(negedge clk);
    TX_Start = 1'b0;
    check_frame("after_rst", 12'h3C6, -1, -1);
    chk("after_rst_done", {31'd0, TX_Done}, 32'd1);
    $display("frame abort/resend data=3c6");
    repeat (4) @(negedge clk);

    // ---- 6: loopback of random words through a mid-bit sampling receiver ----
    for (int i = 0; i < N_LOOP; i++) words[i] = DATA_W'($urandom);
    TX_Data = words[0]; TX_Start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N_LOOP; i++) begin
      if (i < N_LOOP - 1) TX_Data = words[i+1];
      else TX_Start = 1'b0;
      rx = '0;
      bad_framing = 1'b0;
      for (int c = 0; c < FRAME; c++) begin
        if (c % BIT_CLKS == BIT_CLKS / 2) begin
          if (c / BIT_CLKS == 0) begin
            if (UART_TX !== 1'b0) bad_framing = 1'b1;
          end else if (c / BIT_CLKS <= DATA_W) begin
            rx[c / BIT_CLKS - 1] = UART_TX;
          end else begin
            if (UART_TX !== 1'b1) bad_framing = 1'b1;
          end
        end
        @(negedge clk);
      end
      chk("loop_word", {20'd0, rx}, {20'd0, words[i]});
      chk("loop_framing", {31'd0, bad_framing}, 32'd0);
      chk("loop_done", {31'd0, TX_Done}, 32'd1);
      $display("loopback %0d: sent %h received %h", i, words[i], rx);
    end
    chk("loop_busy_end", {31'd0, TX_Busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
